// File: rtl/md5_round_seq.sv
// md5_round_seq: iterative MD5 round engine that runs the 16 steps of one round, UNROLL steps per clock.
// Optional feature macro MD5_ALL_ROUNDS_EN adds run_all: all 64 steps plus chaining-value feedforward.
module md5_round_seq #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   round_sel,
`ifdef MD5_ALL_ROUNDS_EN
  input  logic         run_all,
`endif
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  input  logic [511:0] msg_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
    $error("md5_round_seq: UNROLL must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [6:0] STEP = 7'(UNROLL);

  state_t       r_state, w_next;
  logic [6:0]   r_cnt;
  logic [31:0]  r_a, r_b, r_c, r_d;
  logic [511:0] r_msg;
  logic [1:0]   r_round;
  logic         w_accept, w_all, w_last;
  logic [6:0]   w_total;
  logic [127:0] w_step;

  function automatic logic [31:0] f_fn(input logic [1:0] rnd, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    logic [31:0] f;
    case (rnd)
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (b & d) | (c & ~d);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    return f;
  endfunction

  function automatic logic [3:0] msg_idx(input logic [5:0] g);
    logic [3:0] i, k;
    i = g[3:0];
    case (g[5:4])
      2'd0:    k = i;
      2'd1:    k = 4'd1 + i * 4'd5;
      2'd2:    k = 4'd5 + i * 4'd3;
      default: k = i * 4'd7;
    endcase
    return k;
  endfunction

  function automatic logic [4:0] shift_amt(input logic [5:0] g);
    logic [4:0] s;
    case ({g[5:4], g[1:0]})
      4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
      4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
      4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
      4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  default: s = 5'd21;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] t_rom(input logic [5:0] g);
    logic [31:0] t;
    t = 32'h0;
    case (g)
      6'd0:  t = 32'hd76aa478; 6'd1:  t = 32'he8c7b756; 6'd2:  t = 32'h242070db; 6'd3:  t = 32'hc1bdceee;
      6'd4:  t = 32'hf57c0faf; 6'd5:  t = 32'h4787c62a; 6'd6:  t = 32'ha8304613; 6'd7:  t = 32'hfd469501;
      6'd8:  t = 32'h698098d8; 6'd9:  t = 32'h8b44f7af; 6'd10: t = 32'hffff5bb1; 6'd11: t = 32'h895cd7be;
      6'd12: t = 32'h6b901122; 6'd13: t = 32'hfd987193; 6'd14: t = 32'ha679438e; 6'd15: t = 32'h49b40821;
      6'd16: t = 32'hf61e2562; 6'd17: t = 32'hc040b340; 6'd18: t = 32'h265e5a51; 6'd19: t = 32'he9b6c7aa;
      6'd20: t = 32'hd62f105d; 6'd21: t = 32'h02441453; 6'd22: t = 32'hd8a1e681; 6'd23: t = 32'he7d3fbc8;
      6'd24: t = 32'h21e1cde6; 6'd25: t = 32'hc33707d6; 6'd26: t = 32'hf4d50d87; 6'd27: t = 32'h455a14ed;
      6'd28: t = 32'ha9e3e905; 6'd29: t = 32'hfcefa3f8; 6'd30: t = 32'h676f02d9; 6'd31: t = 32'h8d2a4c8a;
      6'd32: t = 32'hfffa3942; 6'd33: t = 32'h8771f681; 6'd34: t = 32'h6d9d6122; 6'd35: t = 32'hfde5380c;
      6'd36: t = 32'ha4beea44; 6'd37: t = 32'h4bdecfa9; 6'd38: t = 32'hf6bb4b60; 6'd39: t = 32'hbebfbc70;
      6'd40: t = 32'h289b7ec6; 6'd41: t = 32'heaa127fa; 6'd42: t = 32'hd4ef3085; 6'd43: t = 32'h04881d05;
      6'd44: t = 32'hd9d4d039; 6'd45: t = 32'he6db99e5; 6'd46: t = 32'h1fa27cf8; 6'd47: t = 32'hc4ac5665;
      6'd48: t = 32'hf4292244; 6'd49: t = 32'h432aff97; 6'd50: t = 32'hab9423a7; 6'd51: t = 32'hfc93a039;
      6'd52: t = 32'h655b59c3; 6'd53: t = 32'h8f0ccc92; 6'd54: t = 32'hffeff47d; 6'd55: t = 32'h85845dd1;
      6'd56: t = 32'h6fa87e4f; 6'd57: t = 32'hfe2ce6e0; 6'd58: t = 32'ha3014314; 6'd59: t = 32'h4e0811a1;
      6'd60: t = 32'hf7537e82; 6'd61: t = 32'hbd3af235; 6'd62: t = 32'h2ad7d2bb; 6'd63: t = 32'heb86d391;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] y;
    y = {x, x} << s;
    return y[63:32];
  endfunction

  // UNROLL chained steps; global step index g selects round function, message word, shift and T entry.
  function automatic logic [127:0] run_steps(input logic [127:0] st, input logic [5:0] base,
                                             input logic [1:0] rnd, input logic all,
                                             input logic [511:0] msg);
    logic [31:0] a, b, c, d, t, nb;
    logic [5:0]  idx, g;
    logic [3:0]  k;
    {a, b, c, d} = st;
    for (int u = 0; u < UNROLL; u++) begin
      idx = base + 6'(u);
      g   = all ? idx : {rnd, idx[3:0]};
      k   = msg_idx(g);
      t   = a + f_fn(g[5:4], b, c, d) + msg[{k, 5'b00000} +: 32] + t_rom(g);
      nb  = b + rotl(t, shift_amt(g));
      a = d; d = c; c = b; b = nb;
    end
    return {a, b, c, d};
  endfunction

  assign w_accept = in_valid && in_ready;
  assign w_total  = w_all ? 7'd64 : 7'd16;
  assign w_last   = (r_cnt + STEP) == w_total;

  always_comb begin
    w_step = run_steps({r_a, r_b, r_c, r_d}, r_cnt[5:0], r_round, w_all, r_msg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN:  if (w_last) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_msg   <= '0;
      r_round <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_a     <= a_in;
      r_b     <= b_in;
      r_c     <= c_in;
      r_d     <= d_in;
      r_msg   <= msg_in;
      r_round <= round_sel;
    end else if (r_state == RUN) begin
      {r_a, r_b, r_c, r_d} <= w_step;
      r_cnt <= r_cnt + STEP;
    end
  end

`ifdef MD5_ALL_ROUNDS_EN
  logic        r_all;
  logic [31:0] r_a0, r_b0, r_c0, r_d0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_all <= 1'b0;
      r_a0  <= '0;
      r_b0  <= '0;
      r_c0  <= '0;
      r_d0  <= '0;
    end else if (w_accept) begin
      r_all <= run_all;
      r_a0  <= a_in;
      r_b0  <= b_in;
      r_c0  <= c_in;
      r_d0  <= d_in;
    end
  end

  // Full-block runs fold the original chaining value back in.
  assign w_all = r_all;
  assign a_out = r_a + (r_all ? r_a0 : 32'h0);
  assign b_out = r_b + (r_all ? r_b0 : 32'h0);
  assign c_out = r_c + (r_all ? r_c0 : 32'h0);
  assign d_out = r_d + (r_all ? r_d0 : 32'h0);
`else
  assign w_all = 1'b0;
  assign a_out = r_a;
  assign b_out = r_b;
  assign c_out = r_c;
  assign d_out = r_d;
`endif

endmodule

// File: tb/tb_md5_round_seq.sv
// Directed bench for md5_round_seq: five instances (UNROLL 1..16) share stimulus; each test task checks inline.
module tb_md5_round_seq;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready;
  logic [1:0]   round_sel;
  logic [31:0]  a_in, b_in, c_in, d_in;
  logic [511:0] msg_in;
`ifdef MD5_ALL_ROUNDS_EN
  logic         run_all;
`endif
  logic         ir [5];
  logic         ov [5];
  logic [31:0]  oa [5], ob [5], oc [5], od [5];
  int           lat [5];
  int           n_checks = 0;
  int           n_pass = 0;

  localparam logic [127:0] IV   = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam logic [511:0] MSG0 = 512'h80;

  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};

  localparam int S [64] = '{
    7, 12, 17, 22, 7, 12, 17, 22, 7, 12, 17, 22, 7, 12, 17, 22,
    5, 9, 14, 20, 5, 9, 14, 20, 5, 9, 14, 20, 5, 9, 14, 20,
    4, 11, 16, 23, 4, 11, 16, 23, 4, 11, 16, 23, 4, 11, 16, 23,
    6, 10, 15, 21, 6, 10, 15, 21, 6, 10, 15, 21, 6, 10, 15, 21};

  localparam int G [64] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
    1, 6, 11, 0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12,
    5, 8, 11, 14, 1, 4, 7, 10, 13, 0, 3, 6, 9, 12, 15, 2,
    0, 7, 14, 5, 12, 3, 10, 1, 8, 15, 6, 13, 4, 11, 2, 9};

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    md5_round_seq #(.UNROLL(1 << gi)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(ir[gi]),
      .round_sel(round_sel),
`ifdef MD5_ALL_ROUNDS_EN
      .run_all(run_all),
`endif
      .a_in(a_in),
      .b_in(b_in),
      .c_in(c_in),
      .d_in(d_in),
      .msg_in(msg_in),
      .out_valid(ov[gi]),
      .out_ready(out_ready),
      .a_out(oa[gi]),
      .b_out(ob[gi]),
      .c_out(oc[gi]),
      .d_out(od[gi])
    );
  end

  function automatic logic [127:0] model(input logic [127:0] st, input logic [511:0] m,
                                         input int first, input int last);
    logic [31:0] a, b, c, d, f, t, tmp;
    {a, b, c, d} = st;
    for (int j = first; j <= last; j++) begin
      case (j / 16)
        0:       f = (b & c) | (~b & d);
        1:       f = (b & d) | (c & ~d);
        2:       f = b ^ c ^ d;
        default: f = c ^ (b | ~d);
      endcase
      t = a + f + K[j] + m[32*G[j] +: 32];
      tmp = d; d = c; c = b;
      b = b + ((t << S[j]) | (t >> (32 - S[j])));
      a = tmp;
    end
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] make_msg(input int seed);
    logic [511:0] m;
    for (int j = 0; j < 16; j++) m[32*j +: 32] = 32'(j) * 32'h01000193 + 32'h811c9dc5 + 32'(seed);
    return m;
  endfunction

  task automatic start_job(input logic [1:0] rs, input logic [127:0] st, input logic [511:0] m);
    round_sel = rs;
    {a_in, b_in, c_in, d_in} = st;
    msg_in = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // cyc0 counts edges already seen since (and including) the accept edge.
  task automatic wait_done(input int cyc0, input int budget);
    int cyc;
    bit all;
    cyc = cyc0;
    for (int k = 0; k < 5; k++) lat[k] = ov[k] ? cyc : 0;
    all = 1'b0;
    while (!all && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      all = 1'b1;
      for (int k = 0; k < 5; k++) begin
        if (ov[k] && lat[k] == 0) lat[k] = cyc;
        if (lat[k] == 0) all = 1'b0;
      end
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0)
        $display("FAIL reset_low_hs[U=%0d] got in_ready=%b out_valid=%b exp 1/0", 1 << k, ir[k], ov[k]);
      else n_pass++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || {oa[k], ob[k], oc[k], od[k]} !== 128'h0)
        $display("FAIL reset_idle[U=%0d] got rdy=%b vld=%b out=%h exp 1/0/0", 1 << k, ir[k], ov[k],
                 {oa[k], ob[k], oc[k], od[k]});
      else n_pass++;
    end
  endtask

  task automatic test_round0;
    logic [127:0] exp;
    exp = model(IV, MSG0, 0, 15);
    start_job(2'd0, IV, MSG0);
    @(posedge clk); #1;
    n_checks++;
    if (g_dut[0].dut.r_b !== 32'ha5202774)
      $display("FAIL round0_step0_b got %h exp a5202774", g_dut[0].dut.r_b);
    else n_pass++;
    wait_done(2, 40);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (lat[k] !== 16 / (1 << k) + 1)
        $display("FAIL round0_latency[U=%0d] got %0d exp %0d", 1 << k, lat[k], 16 / (1 << k) + 1);
      else n_pass++;
      n_checks++;
      if ({oa[k], ob[k], oc[k], od[k]} !== exp)
        $display("FAIL round0_out[U=%0d] got %h exp %h", 1 << k, {oa[k], ob[k], oc[k], od[k]}, exp);
      else n_pass++;
    end
    release_out;
  endtask

  task automatic test_rounds;
    logic [127:0] st, exp;
    logic [511:0] m;
    for (int rs = 1; rs < 4; rs++) begin
      st  = {32'h01234567 + 32'(rs), 32'h89abcdef, 32'hfedcba98 ^ 32'(rs), 32'h76543210};
      m   = make_msg(rs);
      exp = model(st, m, 16 * rs, 16 * rs + 15);
      start_job(2'(rs), st, m);
      wait_done(1, 40);
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (lat[k] !== 16 / (1 << k) + 1 || {oa[k], ob[k], oc[k], od[k]} !== exp)
          $display("FAIL round%0d[U=%0d] got lat=%0d out=%h exp lat=%0d out=%h", rs, 1 << k, lat[k],
                   {oa[k], ob[k], oc[k], od[k]}, 16 / (1 << k) + 1, exp);
        else n_pass++;
      end
      release_out;
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] st, exp;
    logic [511:0] m;
    st  = 128'hdeadbeef_0badf00d_cafebabe_12345678;
    m   = make_msg(77);
    exp = model(st, m, 32, 47);
    start_job(2'd2, st, m);
    // Scrambled inputs and a pending request while busy must not disturb the latched job.
    {a_in, b_in, c_in, d_in} = ~st;
    msg_in    = ~m;
    round_sel = 2'd1;
    in_valid  = 1'b1;
    wait_done(1, 40);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({oa[k], ob[k], oc[k], od[k]} !== exp)
        $display("FAIL bp_latched[U=%0d] got %h exp %h", 1 << k, {oa[k], ob[k], oc[k], od[k]}, exp);
      else n_pass++;
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 5; k += 4) begin
        n_checks++;
        if (ir[k] !== 1'b0 || ov[k] !== 1'b1 || {oa[k], ob[k], oc[k], od[k]} !== exp)
          $display("FAIL bp_hold[U=%0d,c=%0d] got rdy=%b vld=%b out=%h exp 0/1/%h", 1 << k, c, ir[k], ov[k],
                   {oa[k], ob[k], oc[k], od[k]}, exp);
        else n_pass++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (ir[0] !== 1'b0 || ov[0] !== 1'b1)
      $display("FAIL bp_same_cycle got rdy=%b vld=%b exp 0/1", ir[0], ov[0]);
    else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0)
        $display("FAIL bp_release[U=%0d] got rdy=%b vld=%b exp 1/0", 1 << k, ir[k], ov[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] st, exp;
    logic [511:0] m;
    bit seen;
    st  = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    m   = make_msg(5);
    exp = model(st, m, 48, 63);
    start_job(2'd3, st, m);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || {oa[k], ob[k], oc[k], od[k]} !== 128'h0)
        $display("FAIL midrst_abort[U=%0d] got rdy=%b vld=%b out=%h exp 1/0/0", 1 << k, ir[k], ov[k],
                 {oa[k], ob[k], oc[k], od[k]});
      else n_pass++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) if (ov[k] !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL midrst_no_valid got out_valid=1 exp 0");
    else n_pass++;
    start_job(2'd3, st, m);
    wait_done(1, 40);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (lat[k] !== 16 / (1 << k) + 1 || {oa[k], ob[k], oc[k], od[k]} !== exp)
        $display("FAIL midrst_fresh[U=%0d] got lat=%0d out=%h exp lat=%0d out=%h", 1 << k, lat[k],
                 {oa[k], ob[k], oc[k], od[k]}, 16 / (1 << k) + 1, exp);
      else n_pass++;
    end
    release_out;
  endtask

`ifdef MD5_ALL_ROUNDS_EN
  task automatic test_all_rounds;
    logic [127:0] exp;
    exp = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
    run_all = 1'b1;
    start_job(2'd3, IV, MSG0);
    run_all = 1'b0;
    wait_done(1, 80);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (lat[k] !== 64 / (1 << k) + 1 || {oa[k], ob[k], oc[k], od[k]} !== exp)
        $display("FAIL all_rounds[U=%0d] got lat=%0d out=%h exp lat=%0d out=%h", 1 << k, lat[k],
                 {oa[k], ob[k], oc[k], od[k]}, 64 / (1 << k) + 1, exp);
      else n_pass++;
    end
    release_out;
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    round_sel = 2'd0;
    a_in      = '0;
    b_in      = '0;
    c_in      = '0;
    d_in      = '0;
    msg_in    = '0;
`ifdef MD5_ALL_ROUNDS_EN
    run_all   = 1'b0;
`endif
    test_reset;
    test_round0;
    test_rounds;
    test_backpressure;
    test_reset_mid;
`ifdef MD5_ALL_ROUNDS_EN
    test_all_rounds;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
